// File: rtl/chess_clock_pkg.sv
// Shared constants for the chess clock countdown core: FSM encoding,
// BCD minute presets and the preset priority encoder.
package chess_clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READY   = 3'd1;
  localparam logic [2:0] ST_RUN_P1  = 3'd2;
  localparam logic [2:0] ST_RUN_P2  = 3'd3;
  localparam logic [2:0] ST_PAUSED  = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;

  // Minutes as two BCD digits {M10, M1}.
  localparam logic [7:0] PRESET_D1 = 8'h01;
  localparam logic [7:0] PRESET_D2 = 8'h03;
  localparam logic [7:0] PRESET_D3 = 8'h05;
  localparam logic [7:0] PRESET_D4 = 8'h10;
  localparam logic [7:0] PRESET_D5 = 8'h15;
  localparam logic [7:0] PRESET_D6 = 8'h30;
  localparam logic [7:0] PRESET_D7 = 8'h60;
  localparam logic [7:0] PRESET_D8 = 8'h90;

  // sel[0] is D1; the lowest set bit wins.
  function automatic logic [7:0] preset_minutes(input logic [7:0] sel);
    logic [7:0] mins;
    mins = 8'h00;
    if      (sel[0]) mins = PRESET_D1;
    else if (sel[1]) mins = PRESET_D2;
    else if (sel[2]) mins = PRESET_D3;
    else if (sel[3]) mins = PRESET_D4;
    else if (sel[4]) mins = PRESET_D5;
    else if (sel[5]) mins = PRESET_D6;
    else if (sel[6]) mins = PRESET_D7;
    else if (sel[7]) mins = PRESET_D8;
    return mins;
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// One player's mm:ss BCD down-counter with parallel minute load.
// Saturates at 00:00; AT_ONE lets the FSM predict the terminal tick.
module bcd_mmss_down
  import chess_clock_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               LOAD,
  input  logic [DIGIT_W-1:0] LOAD_M10,
  input  logic [DIGIT_W-1:0] LOAD_M1,
  input  logic               DEC,
  output logic [DIGIT_W-1:0] M10,
  output logic [DIGIT_W-1:0] M1,
  output logic [DIGIT_W-1:0] S10,
  output logic [DIGIT_W-1:0] S1,
  output logic               ZERO,
  output logic               AT_ONE
);

  logic [DIGIT_W-1:0] m10_q, m10_d, m1_q, m1_d, s10_q, s10_d, s1_q, s1_d;

  assign ZERO   = (m10_q == '0) && (m1_q == '0) && (s10_q == '0) && (s1_q == '0);
  assign AT_ONE = (m10_q == '0) && (m1_q == '0) && (s10_q == '0) && (s1_q == 4'd1);

  always_comb begin
    // NOTE: every *_d gets a default first so no path can infer a latch.
    m10_d = m10_q;
    m1_d  = m1_q;
    s10_d = s10_q;
    s1_d  = s1_q;
    if (LOAD) begin
      m10_d = LOAD_M10;
      m1_d  = LOAD_M1;
      s10_d = '0;
      s1_d  = '0;
    end else if (DEC && !ZERO) begin
      // Borrow ripples up only while the lower digit wraps.
      if (s1_q != '0) s1_d = s1_q - 4'd1;
      else begin
        s1_d = 4'd9;
        if (s10_q != '0) s10_d = s10_q - 4'd1;
        else begin
          s10_d = 4'd5;
          if (m1_q != '0) m1_d = m1_q - 4'd1;
          else begin
            m1_d  = 4'd9;
            m10_d = m10_q - 4'd1;
          end
        end
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m10_q <= '0;
      m1_q  <= '0;
      s10_q <= '0;
      s1_q  <= '0;
    end else if (CE) begin
      m10_q <= m10_d;
      m1_q  <= m1_d;
      s10_q <= s10_d;
      s1_q  <= s1_d;
    end
  end

  assign M10 = m10_q;
  assign M1  = m1_q;
  assign S10 = s10_q;
  assign S1  = s1_q;

endmodule

// File: rtl/chess_countdown.sv
// Dual-player chess clock core: preset load, turn FSM, per-player
// BCD countdown and sticky timeout flags.
module chess_countdown
  import chess_clock_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               D1,
  input  logic               D2,
  input  logic               D3,
  input  logic               D4,
  input  logic               D5,
  input  logic               D6,
  input  logic               D7,
  input  logic               D8,
  input  logic               TICK,
  input  logic               P1_BTN,
  input  logic               P2_BTN,
  input  logic               STOP,
  output logic [DIGIT_W-1:0] P1_M10,
  output logic [DIGIT_W-1:0] P1_M1,
  output logic [DIGIT_W-1:0] P1_S10,
  output logic [DIGIT_W-1:0] P1_S1,
  output logic [DIGIT_W-1:0] P2_M10,
  output logic [DIGIT_W-1:0] P2_M1,
  output logic [DIGIT_W-1:0] P2_S10,
  output logic [DIGIT_W-1:0] P2_S1,
  output logic               ACTIVE,
  output logic               RUNNING,
  output logic               FLAG_P1,
  output logic               FLAG_P2
);

  logic [2:0] state_q, state_d;
  logic       active_q, active_d;
  logic       running_q, running_d;
  logic       flag_p1_q, flag_p1_d;
  logic       flag_p2_q, flag_p2_d;

  logic [7:0] d_sel;
  logic [7:0] preset;
  logic       load_req;
  logic       dec_p1, dec_p2;
  logic       p1_zero, p1_at_one, p2_zero, p2_at_one;

  assign d_sel    = {D8, D7, D6, D5, D4, D3, D2, D1};
  assign preset   = preset_minutes(d_sel);
  assign load_req = (|d_sel) && (state_q != ST_RUN_P1) && (state_q != ST_RUN_P2);

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    flag_p1_d = flag_p1_q;
    flag_p2_d = flag_p2_q;
    dec_p1    = 1'b0;
    dec_p2    = 1'b0;
    if (load_req) begin
      state_d   = ST_READY;
      active_d  = 1'b0;
      flag_p1_d = 1'b0;
      flag_p2_d = 1'b0;
    end else begin
      case (state_q)
        ST_READY: if (P2_BTN && !STOP) state_d = ST_RUN_P1;
        ST_RUN_P1: begin
          if (STOP) state_d = ST_PAUSED;
          else begin
            dec_p1 = TICK && !p1_zero;
            // A terminal tick beats a coincident move: the swap is dropped.
            if (TICK && p1_at_one) begin
              state_d   = ST_TIMEOUT;
              flag_p1_d = 1'b1;
            end else if (P1_BTN) begin
              state_d  = ST_RUN_P2;
              active_d = 1'b1;
            end
          end
        end
        ST_RUN_P2: begin
          if (STOP) state_d = ST_PAUSED;
          else begin
            dec_p2 = TICK && !p2_zero;
            if (TICK && p2_at_one) begin
              state_d   = ST_TIMEOUT;
              flag_p2_d = 1'b1;
            end else if (P2_BTN) begin
              state_d  = ST_RUN_P1;
              active_d = 1'b0;
            end
          end
        end
        ST_PAUSED: if (!STOP) state_d = active_q ? ST_RUN_P2 : ST_RUN_P1;
        default: ;
      endcase
    end
    running_d = (state_d == ST_RUN_P1) || (state_d == ST_RUN_P2);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      running_q <= 1'b0;
      flag_p1_q <= 1'b0;
      flag_p2_q <= 1'b0;
    end else if (CE) begin
      state_q   <= state_d;
      active_q  <= active_d;
      running_q <= running_d;
      flag_p1_q <= flag_p1_d;
      flag_p2_q <= flag_p2_d;
    end
  end

  bcd_mmss_down u_p1 (
    .CLK      (CLK),
    .CLR      (CLR),
    .CE       (CE),
    .LOAD     (load_req),
    .LOAD_M10 (preset[7:4]),
    .LOAD_M1  (preset[3:0]),
    .DEC      (dec_p1),
    .M10      (P1_M10),
    .M1       (P1_M1),
    .S10      (P1_S10),
    .S1       (P1_S1),
    .ZERO     (p1_zero),
    .AT_ONE   (p1_at_one)
  );

  bcd_mmss_down u_p2 (
    .CLK      (CLK),
    .CLR      (CLR),
    .CE       (CE),
    .LOAD     (load_req),
    .LOAD_M10 (preset[7:4]),
    .LOAD_M1  (preset[3:0]),
    .DEC      (dec_p2),
    .M10      (P2_M10),
    .M1       (P2_M1),
    .S10      (P2_S10),
    .S1       (P2_S1),
    .ZERO     (p2_zero),
    .AT_ONE   (p2_at_one)
  );

  assign ACTIVE  = active_q;
  assign RUNNING = running_q;
  assign FLAG_P1 = flag_p1_q;
  assign FLAG_P2 = flag_p2_q;

endmodule

// File: tb/tb_chess_countdown.sv
// Directed bench for chess_countdown: a vector table for single-cycle
// behaviour plus hand-written countdown, timeout and reset sequences.
module tb_chess_countdown;

  logic       CLK, CLR, CE, TICK, P1_BTN, P2_BTN, STOP;
  logic       D1, D2, D3, D4, D5, D6, D7, D8;
  logic [3:0] P1_M10, P1_M1, P1_S10, P1_S1, P2_M10, P2_M1, P2_S10, P2_S1;
  logic       ACTIVE, RUNNING, FLAG_P1, FLAG_P2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  d;
    logic        tick, p1, p2, stop, ce;
    logic [15:0] e_p1, e_p2;
    logic        e_act, e_run, e_f1, e_f2;
  } vec_t;

  vec_t vq[$];

  chess_countdown dut (
    .CLK(CLK), .CLR(CLR), .CE(CE),
    .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
    .TICK(TICK), .P1_BTN(P1_BTN), .P2_BTN(P2_BTN), .STOP(STOP),
    .P1_M10(P1_M10), .P1_M1(P1_M1), .P1_S10(P1_S10), .P1_S1(P1_S1),
    .P2_M10(P2_M10), .P2_M1(P2_M1), .P2_S10(P2_S10), .P2_S1(P2_S1),
    .ACTIVE(ACTIVE), .RUNNING(RUNNING), .FLAG_P1(FLAG_P1), .FLAG_P2(FLAG_P2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] p1_time();
    return {P1_M10, P1_M1, P1_S10, P1_S1};
  endfunction

  function automatic logic [15:0] p2_time();
    return {P2_M10, P2_M1, P2_S10, P2_S1};
  endfunction

  // Reference decrement through plain seconds, saturating at zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    int s;
    s = 600 * int'(t[15:12]) + 60 * int'(t[11:8]) + 10 * int'(t[7:4]) + int'(t[3:0]);
    if (s > 0) s = s - 1;
    return {4'(s / 600), 4'((s % 600) / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                           input logic ea, input logic er, input logic ef1, input logic ef2);
    check({tag, " p1_time"}, p1_time(), e1);
    check({tag, " p2_time"}, p2_time(), e2);
    check({tag, " active"},  {15'd0, ACTIVE},  {15'd0, ea});
    check({tag, " running"}, {15'd0, RUNNING}, {15'd0, er});
    check({tag, " flag_p1"}, {15'd0, FLAG_P1}, {15'd0, ef1});
    check({tag, " flag_p2"}, {15'd0, FLAG_P2}, {15'd0, ef2});
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic drive(input logic [7:0] d, input logic tick, input logic p1,
                       input logic p2, input logic stop, input logic ce);
    @(negedge CLK);
    {D8, D7, D6, D5, D4, D3, D2, D1} = d;
    TICK = tick; P1_BTN = p1; P2_BTN = p2; STOP = stop; CE = ce;
    @(posedge CLK);
    #1;
  endtask

  task automatic addv(input logic [7:0] d, input logic tick, input logic p1, input logic p2,
                      input logic stop, input logic ce, input logic [15:0] e1, input logic [15:0] e2,
                      input logic ea, input logic er, input logic ef1, input logic ef2);
    vq.push_back('{d, tick, p1, p2, stop, ce, e1, e2, ea, er, ef1, ef2});
  endtask

  initial begin
    logic [15:0] exp1, exp2;

    //    d      tk p1 p2 st ce  p1      p2      act run f1 f2
    addv(8'h08, 0, 0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0, 0); // D4 load
    addv(8'h00, 0, 1, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0, 0); // P1_BTN ignored in READY
    addv(8'h00, 1, 0, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0, 0); // TICK ignored in READY
    addv(8'h01, 0, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0, 0, 0); // D1 reload
    addv(8'h00, 0, 0, 1, 0, 1, 16'h0100, 16'h0100, 0, 1, 0, 0); // P2_BTN starts P1
    addv(8'h00, 1, 0, 0, 0, 1, 16'h0059, 16'h0100, 0, 1, 0, 0);
    addv(8'h00, 1, 0, 0, 0, 1, 16'h0058, 16'h0100, 0, 1, 0, 0);
    addv(8'h00, 1, 0, 0, 0, 1, 16'h0057, 16'h0100, 0, 1, 0, 0);
    addv(8'h00, 0, 0, 1, 0, 1, 16'h0057, 16'h0100, 0, 1, 0, 0); // P2_BTN ignored in RUN_P1
    addv(8'h00, 1, 0, 0, 0, 0, 16'h0057, 16'h0100, 0, 1, 0, 0); // CE low freezes TICK
    addv(8'h02, 0, 1, 0, 0, 0, 16'h0057, 16'h0100, 0, 1, 0, 0); // CE low freezes btn/load
    addv(8'h02, 0, 0, 0, 0, 1, 16'h0057, 16'h0100, 0, 1, 0, 0); // load ignored while running
    addv(8'h00, 0, 1, 1, 0, 1, 16'h0057, 16'h0100, 1, 1, 0, 0); // both buttons: P1 counts
    addv(8'h00, 1, 0, 0, 0, 1, 16'h0057, 16'h0059, 1, 1, 0, 0);
    addv(8'h00, 1, 0, 0, 1, 1, 16'h0057, 16'h0059, 1, 0, 0, 0); // STOP beats TICK
    addv(8'h00, 1, 0, 0, 1, 1, 16'h0057, 16'h0059, 1, 0, 0, 0); // TICK ignored in PAUSED
    addv(8'h00, 0, 0, 1, 1, 1, 16'h0057, 16'h0059, 1, 0, 0, 0); // button ignored in PAUSED
    addv(8'h00, 0, 0, 0, 0, 1, 16'h0057, 16'h0059, 1, 1, 0, 0); // resume into RUN_P2
    addv(8'h00, 1, 0, 1, 0, 1, 16'h0057, 16'h0058, 0, 1, 0, 0); // TICK+move: dec then swap
    addv(8'h00, 1, 0, 0, 0, 1, 16'h0056, 16'h0058, 0, 1, 0, 0);

    CLR = 1'b1; CE = 1'b1; TICK = 1'b0; P1_BTN = 1'b0; P2_BTN = 1'b0; STOP = 1'b0;
    {D8, D7, D6, D5, D4, D3, D2, D1} = 8'h00;
    repeat (2) @(posedge CLK);
    #1 check_out("reset", 16'h0000, 16'h0000, 0, 0, 0, 0);
    @(negedge CLK) CLR = 1'b0;
    drive(8'h00, 0, 0, 1, 0, 1);
    check_out("idle_ignores_btn", 16'h0000, 16'h0000, 0, 0, 0, 0);

    foreach (vq[i])
      begin
        drive(vq[i].d, vq[i].tick, vq[i].p1, vq[i].p2, vq[i].stop, vq[i].ce);
        check_out($sformatf("vec%0d", i), vq[i].e_p1, vq[i].e_p2,
                  vq[i].e_act, vq[i].e_run, vq[i].e_f1, vq[i].e_f2);
      end

    // P1 down to 00:30, then TICK with P1_BTN: decrement, then swap.
    exp1 = 16'h0056;
    for (int i = 0; i < 26; i++) begin
      exp1 = bcd_dec(exp1);
      drive(8'h00, 1, 0, 0, 0, 1);
      check_out("count_p1", exp1, 16'h0058, 0, 1, 0, 0);
    end
    check("p1_at_30", p1_time(), 16'h0030);
    drive(8'h00, 1, 1, 0, 0, 1);
    check_out("tick_and_swap", 16'h0029, 16'h0058, 1, 1, 0, 0);

    // Pause, reload with STOP held; start blocked until STOP drops.
    drive(8'h00, 0, 0, 0, 1, 1);
    check_out("pause_p2", 16'h0029, 16'h0058, 1, 0, 0, 0);
    drive(8'h08, 0, 0, 0, 1, 1);
    check_out("load_beats_stop", 16'h1000, 16'h1000, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 1, 1, 1);
    check_out("ready_stop_blocks", 16'h1000, 16'h1000, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 1, 0, 1);
    check_out("start_p1", 16'h1000, 16'h1000, 0, 1, 0, 0);
    drive(8'h00, 0, 1, 0, 0, 1);
    check_out("swap_to_p2", 16'h1000, 16'h1000, 1, 1, 0, 0);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("borrow_chain", 16'h1000, 16'h0959, 1, 1, 0, 0);

    // Full borrow cascade down to 00:01, then the terminal tick.
    exp2 = 16'h0959;
    for (int i = 0; i < 598; i++) begin
      exp2 = bcd_dec(exp2);
      drive(8'h00, 1, 0, 0, 0, 1);
      check_out("count_p2", 16'h1000, exp2, 1, 1, 0, 0);
    end
    check("p2_at_one", p2_time(), 16'h0001);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("timeout_p2", 16'h1000, 16'h0000, 1, 0, 0, 1);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("timeout_tick", 16'h1000, 16'h0000, 1, 0, 0, 1);
    drive(8'h00, 0, 0, 1, 0, 1);
    check_out("timeout_p2btn", 16'h1000, 16'h0000, 1, 0, 0, 1);
    drive(8'h00, 0, 1, 0, 0, 1);
    check_out("timeout_p1btn", 16'h1000, 16'h0000, 1, 0, 0, 1);

    // D8 with D3: lowest index wins; load exits TIMEOUT and clears flags.
    drive(8'h84, 0, 0, 0, 0, 1);
    check_out("prio_from_timeout", 16'h0500, 16'h0500, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 1, 0, 1);
    drive(8'h00, 0, 1, 0, 0, 1);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("p2_running", 16'h0500, 16'h0459, 1, 1, 0, 0);
    drive(8'h00, 0, 0, 0, 1, 1);
    check_out("paused_again", 16'h0500, 16'h0459, 1, 0, 0, 0);
    drive(8'h84, 0, 0, 0, 1, 1);
    check_out("prio_from_paused", 16'h0500, 16'h0500, 0, 0, 0, 0);

    // P1 timeout coinciding with its own move: swap is dropped.
    drive(8'h01, 0, 0, 0, 1, 1);
    check_out("load_1min", 16'h0100, 16'h0100, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 1, 0, 1);
    exp1 = 16'h0100;
    for (int i = 0; i < 59; i++) begin
      exp1 = bcd_dec(exp1);
      drive(8'h00, 1, 0, 0, 0, 1);
      check_out("count_p1_1min", exp1, 16'h0100, 0, 1, 0, 0);
    end
    drive(8'h00, 1, 1, 0, 0, 1);
    check_out("timeout_beats_swap", 16'h0000, 16'h0100, 0, 0, 1, 0);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("flag_sticky", 16'h0000, 16'h0100, 0, 0, 1, 0);

    // Asynchronous CLR in the middle of a count.
    drive(8'h10, 0, 0, 0, 0, 1);
    check_out("load_15min", 16'h1500, 16'h1500, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 1, 0, 1);
    drive(8'h00, 1, 0, 0, 0, 1);
    drive(8'h00, 0, 1, 0, 0, 1);
    drive(8'h00, 1, 0, 0, 0, 1);
    check_out("pre_clr", 16'h1459, 16'h1459, 1, 1, 0, 0);
    #2 CLR = 1'b1;
    #1 check_out("async_clr", 16'h0000, 16'h0000, 0, 0, 0, 0);
    @(negedge CLK) CLR = 1'b0;
    drive(8'h00, 1, 0, 1, 0, 1);
    check_out("idle_after_clr", 16'h0000, 16'h0000, 0, 0, 0, 0);
    drive(8'h10, 0, 0, 0, 0, 1);
    check_out("load_after_clr", 16'h1500, 16'h1500, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chess_countdown.md
# chess_countdown

Dual-player countdown core of the chess clock, directly downstream of the time-setter stage. It consumes the setter's eight one-bit preset lines, D1..D8, which are valid for one cycle while the clock is stopped. It loads the selected time control into both players' BCD mm:ss counters and counts the active player down on a 1 Hz tick. It also swaps sides on move buttons and flags timeout to the display and buzzer logic.

## Interface
- No parameters; preset table fixed in package.
- CLK  in  1  system clock, all state on rising edge
- CLR  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; low freezes all state, inputs ignored
- D1..D8  in  1 each  one-hot preset select from setter; any bit high = load request
- TICK  in  1  single-cycle 1 Hz strobe
- P1_BTN, P2_BTN  in  1 each  single-cycle move-done pulses (debounced upstream)
- STOP  in  1  level; high pauses play
- P1_M10, P1_M1, P1_S10, P1_S1  out  4 each  player 1 BCD time
- P2_M10, P2_M1, P2_S10, P2_S1  out  4 each  player 2 BCD time
- ACTIVE  out  1  0 = player 1 to move, 1 = player 2
- RUNNING  out  1  high in RUN_P1/RUN_P2
- FLAG_P1, FLAG_P2  out  1 each  player's time expired (sticky)

## Operation
- Presets (minutes):
  - D1=1, D2=3, D3=5, D4=10
  - D5=15, D6=30, D7=60, D8=90
  - Several bits high: lowest index wins. Seconds load as 00.
- Load accepted in IDLE, READY, PAUSED, TIMEOUT; ignored in RUN_P1/RUN_P2. Load:
  - sets both players to the preset;
  - clears both flags;
  - sets ACTIVE=0;
  - moves to READY.
- States:
  - IDLE: reset state, times 00:00.
  - READY: P2_BTN -> RUN_P1 (black starts white's clock); P1_BTN ignored.
  - RUN_P1: TICK decrements P1. P1_BTN -> RUN_P2, ACTIVE=1. P2_BTN ignored. STOP high -> PAUSED.
  - RUN_P2: symmetric; P2_BTN -> RUN_P1, ACTIVE=0.
  - PAUSED: buttons and TICK ignored; STOP low -> RUN state selected by ACTIVE.
  - TIMEOUT: counting stops; exits only on load or CLR.
- BCD decrement, active player only:
  - S1 0->9 with borrow; S10 0->5 with borrow; M1 0->9 with borrow; M10 decrements.
  - Never decrements below 00:00.
- Decrement reaching 00:00 -> TIMEOUT, and the active player's FLAG set on the same edge.
- Simultaneous events:
  - TICK + active button: decrement the mover first, then swap. If the decrement reaches zero, TIMEOUT wins and the swap is dropped.
  - STOP + button or TICK in a RUN state: STOP wins; both are ignored.
  - Both buttons at once: only the active player's button counts.
  - Load + STOP in PAUSED: load wins -> READY. Entering READY with STOP still high is allowed; a P2_BTN press is ignored while STOP is high.
- CE low: no state change regardless of inputs.

## Timing
- All outputs registered; one-cycle latency from input event to output change.
- CLR asserted at any time, including mid-count: immediately forces IDLE.
  - All digit outputs become 0; ACTIVE=0, RUNNING=0, FLAG_P1=FLAG_P2=0.
- Load pulse is one cycle wide; the counters show the preset on the next edge.
- TICK is sampled only on cycles where it is high; a held TICK decrements every cycle. Upstream must guarantee a one-cycle strobe.

## Structure
- Package chess_clock_pkg holds:
  - state encoding: IDLE, READY, RUN_P1, RUN_P2, PAUSED, TIMEOUT;
  - preset BCD minute constants for D1..D8;
  - BCD digit width constant (4).
- Sub-module bcd_mmss_down, instantiated twice (one per player):
  - inputs: CLK, CLR, CE, LOAD, LOAD_M10, LOAD_M1, DEC;
  - outputs: four digits, ZERO (combinational 00:00 flag), and AT_ONE (value equals 00:01) used by the FSM to predict timeout.
- Top level contains the FSM, preset priority encoder and output registers.

## Test plan
- Reset then load:
  - CLR pulse -> all outputs 0, IDLE.
  - D4 pulse -> both players 10:00, ACTIVE=0, RUNNING=0.
- Start and count:
  - Load D1, P2_BTN, then 3 TICKs -> P1 shows 00:57, P2 01:00, RUNNING=1.
- Swap with coincident tick:
  - In RUN_P1 at 00:30, TICK and P1_BTN in the same cycle -> P1 00:29, ACTIVE=1, RUN_P2.
- Borrow chain and timeout:
  - P2 at 10:00, TICK -> 09:59.
  - Continue to 00:01, TICK -> 00:00, FLAG_P2=1, RUNNING=0; further TICK/buttons produce no change.
- Pause and reload:
  - STOP high in RUN_P2 -> PAUSED; TICK has no effect.
  - D8 and D3 together -> D3 wins: both 05:00, READY.
- CE and priority:
  - CE low with TICK/P1_BTN -> no change.
  - Mid-count CLR -> IDLE with zeroed outputs next observation.
